// File: rtl/lbm_de_2.sv
`default_nettype none
// ==========================================================================
// lbm_de_2 : free-running D2Q9 BGK (tau=1) lattice-Boltzmann engine on a
//            16x16 periodic lattice, Q8.24 fixed point, ping-pong banks.
// Revision  : 1.0
// ==========================================================================
module lbm_de_2 #(
  parameter int GRID_DIM        = 256,
  parameter int DATA_WIDTH      = 32,
  parameter int ADDRESS_WIDTH   = $clog2(GRID_DIM),
  parameter int DATA_WIDTH_F    = 9 * DATA_WIDTH,
  parameter int FRACTIONAL_BITS = 24,
  parameter int INTEGER_BITS    = DATA_WIDTH - FRACTIONAL_BITS,
  parameter int BUMP_ADDR       = 136
) (
  input  logic                           CLOCK_50,
  input  logic                           RESET,
  output logic signed [DATA_WIDTH-1:0]   p_mem_data_out,
  output logic signed [DATA_WIDTH-1:0]   ux_mem_data_out,
  output logic signed [DATA_WIDTH-1:0]   uy_mem_data_out,
  output logic signed [DATA_WIDTH_F-1:0] fin_mem_data_out
);

  localparam int SIDE_BITS = ADDRESS_WIDTH / 2;
  localparam int NDIR      = 9;

  localparam logic signed [DATA_WIDTH-1:0] C_ONE   = DATA_WIDTH'(1) << (DATA_WIDTH - INTEGER_BITS);
  localparam logic signed [DATA_WIDTH-1:0] C_1P5   = C_ONE + (C_ONE >>> 1);
  localparam logic signed [DATA_WIDTH-1:0] C_THREE = C_ONE + C_ONE + C_ONE;
  localparam logic signed [DATA_WIDTH-1:0] C_4P5   = C_THREE + C_1P5;
  localparam logic signed [DATA_WIDTH-1:0] C_W0    = DATA_WIDTH'(32'h0071C71C);
  localparam logic signed [DATA_WIDTH-1:0] C_W1    = DATA_WIDTH'(32'h001C71C7);
  localparam logic signed [DATA_WIDTH-1:0] C_W5    = DATA_WIDTH'(32'h00071C71);

  typedef enum logic [2:0] {
    ST_INIT    = 3'd0,
    ST_STREAM  = 3'd1,
    ST_COLLIDE = 3'd2,
    ST_WRITE   = 3'd3,
    ST_SWAP    = 3'd4
  } state_t;

  function automatic logic signed [DATA_WIDTH-1:0] fx_mul(
    input logic signed [DATA_WIDTH-1:0] a,
    input logic signed [DATA_WIDTH-1:0] b
  );
    logic signed [2*DATA_WIDTH-1:0] prod;
    prod = (2*DATA_WIDTH)'(a) * (2*DATA_WIDTH)'(b);
    return DATA_WIDTH'(prod >>> FRACTIONAL_BITS);
  endfunction

  function automatic logic signed [DATA_WIDTH-1:0] weight(input int i);
    if (i == 0)     return C_W0;
    else if (i < 5) return C_W1;
    else            return C_W5;
  endfunction

  state_t                         state_q, state_d;
  logic [ADDRESS_WIDTH-1:0]       addr_q, addr_d;
  logic [ADDRESS_WIDTH-1:0]       last_addr_q, last_addr_d;
  logic [3:0]                     dir_q, dir_d;
  logic                           src_q, src_d;
  logic                           valid_q, valid_d;
  logic signed [DATA_WIDTH-1:0]   f_q [NDIR];
  logic signed [DATA_WIDTH-1:0]   f_d [NDIR];
  logic signed [DATA_WIDTH-1:0]   rho_q, rho_d, ux_q, ux_d, uy_q, uy_d;
  logic [DATA_WIDTH_F-1:0]        feq_q, feq_d;
  logic signed [DATA_WIDTH_F-1:0] fin_q, fin_d;

  logic [DATA_WIDTH_F-1:0]        bank0_mem [GRID_DIM];
  logic [DATA_WIDTH_F-1:0]        bank1_mem [GRID_DIM];
  logic signed [DATA_WIDTH-1:0]   rho_mem   [GRID_DIM];
  logic signed [DATA_WIDTH-1:0]   ux_mem    [GRID_DIM];
  logic signed [DATA_WIDTH-1:0]   uy_mem    [GRID_DIM];

  logic [SIDE_BITS-1:0]           cell_x, cell_y, nb_x, nb_y;
  logic [ADDRESS_WIDTH-1:0]       nb_addr;
  logic signed [DATA_WIDTH-1:0]   rd_word;

  logic signed [DATA_WIDTH-1:0]   init_rho;
  logic [DATA_WIDTH_F-1:0]        init_f;

  logic signed [DATA_WIDTH-1:0]   rho_c, ux_c, uy_c, usq_c, t_c;
  logic signed [DATA_WIDTH-1:0]   cu_c [NDIR];
  logic [DATA_WIDTH_F-1:0]        feq_c;

  // Pull f_i from the upstream neighbour: (x - cx_i, y - cy_i) with wrap.
  always_comb begin
    cell_x = addr_q[SIDE_BITS-1:0];
    cell_y = addr_q[ADDRESS_WIDTH-1:SIDE_BITS];
    nb_x   = cell_x;
    nb_y   = cell_y;
    case (dir_q)
      4'd1: nb_x = cell_x - 1'b1;
      4'd2: nb_y = cell_y - 1'b1;
      4'd3: nb_x = cell_x + 1'b1;
      4'd4: nb_y = cell_y + 1'b1;
      4'd5: begin nb_x = cell_x - 1'b1; nb_y = cell_y - 1'b1; end
      4'd6: begin nb_x = cell_x + 1'b1; nb_y = cell_y - 1'b1; end
      4'd7: begin nb_x = cell_x + 1'b1; nb_y = cell_y + 1'b1; end
      4'd8: begin nb_x = cell_x - 1'b1; nb_y = cell_y + 1'b1; end
      default: ;
    endcase
    nb_addr = {nb_y, nb_x};
    rd_word = src_q ? bank1_mem[nb_addr][int'(dir_q)*DATA_WIDTH +: DATA_WIDTH]
                    : bank0_mem[nb_addr][int'(dir_q)*DATA_WIDTH +: DATA_WIDTH];
  end

  always_comb begin
    init_rho = (addr_q == ADDRESS_WIDTH'(BUMP_ADDR)) ? C_1P5 : C_ONE;
    init_f   = '0;
    for (int i = 0; i < NDIR; i++)
      init_f[i*DATA_WIDTH +: DATA_WIDTH] = fx_mul(weight(i), init_rho);
  end

  // Velocity is the raw momentum: the incompressible form omits the 1/rho.
  always_comb begin
    rho_c = '0;
    for (int i = 0; i < NDIR; i++) rho_c = rho_c + f_q[i];
    ux_c  = f_q[1] - f_q[3] + f_q[5] - f_q[6] - f_q[7] + f_q[8];
    uy_c  = f_q[2] - f_q[4] + f_q[5] + f_q[6] - f_q[7] - f_q[8];
    usq_c = fx_mul(ux_c, ux_c) + fx_mul(uy_c, uy_c);
    cu_c[0] = '0;
    cu_c[1] = ux_c;
    cu_c[2] = uy_c;
    cu_c[3] = -ux_c;
    cu_c[4] = -uy_c;
    cu_c[5] = ux_c + uy_c;
    cu_c[6] = uy_c - ux_c;
    cu_c[7] = -ux_c - uy_c;
    cu_c[8] = ux_c - uy_c;
    t_c   = '0;
    feq_c = '0;
    for (int i = 0; i < NDIR; i++) begin
      t_c = rho_c + fx_mul(C_THREE, cu_c[i])
                  + fx_mul(C_4P5, fx_mul(cu_c[i], cu_c[i]))
                  - fx_mul(C_1P5, usq_c);
      feq_c[i*DATA_WIDTH +: DATA_WIDTH] = fx_mul(weight(i), t_c);
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    last_addr_d = last_addr_q;
    dir_d       = dir_q;
    src_d       = src_q;
    valid_d     = valid_q;
    f_d         = f_q;
    rho_d       = rho_q;
    ux_d        = ux_q;
    uy_d        = uy_q;
    feq_d       = feq_q;
    fin_d       = fin_q;
    case (state_q)
      ST_INIT: begin
        addr_d = addr_q + 1'b1;
        if (addr_q == ADDRESS_WIDTH'(GRID_DIM - 1)) begin
          addr_d  = '0;
          state_d = ST_STREAM;
        end
      end
      ST_STREAM: begin
        f_d[dir_q] = rd_word;
        if (dir_q == 4'd8) begin
          dir_d   = '0;
          state_d = ST_COLLIDE;
        end else begin
          dir_d = dir_q + 1'b1;
        end
      end
      ST_COLLIDE: begin
        rho_d   = rho_c;
        ux_d    = ux_c;
        uy_d    = uy_c;
        feq_d   = feq_c;
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        fin_d       = feq_q;
        valid_d     = 1'b1;
        last_addr_d = addr_q;
        if (addr_q == ADDRESS_WIDTH'(GRID_DIM - 1)) begin
          addr_d  = '0;
          state_d = ST_SWAP;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = ST_STREAM;
        end
      end
      ST_SWAP: begin
        src_d   = ~src_q;
        state_d = ST_STREAM;
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge RESET) begin
    if (!RESET) begin
      state_q     <= ST_INIT;
      addr_q      <= '0;
      last_addr_q <= '0;
      dir_q       <= '0;
      src_q       <= 1'b0;
      valid_q     <= 1'b0;
      for (int i = 0; i < NDIR; i++) f_q[i] <= '0;
      rho_q       <= '0;
      ux_q        <= '0;
      uy_q        <= '0;
      feq_q       <= '0;
      fin_q       <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      last_addr_q <= last_addr_d;
      dir_q       <= dir_d;
      src_q       <= src_d;
      valid_q     <= valid_d;
      f_q         <= f_d;
      rho_q       <= rho_d;
      ux_q        <= ux_d;
      uy_q        <= uy_d;
      feq_q       <= feq_d;
      fin_q       <= fin_d;
    end
  end

  // src_q=0 means bank0 is read, so results land in bank1, and vice versa.
  always_ff @(posedge CLOCK_50) begin
    if (state_q == ST_INIT) begin
      bank0_mem[addr_q] <= init_f;
      rho_mem[addr_q]   <= init_rho;
      ux_mem[addr_q]    <= '0;
      uy_mem[addr_q]    <= '0;
    end else if (state_q == ST_WRITE) begin
      if (src_q) bank0_mem[addr_q] <= feq_q;
      else       bank1_mem[addr_q] <= feq_q;
      rho_mem[addr_q] <= rho_q;
      ux_mem[addr_q]  <= ux_q;
      uy_mem[addr_q]  <= uy_q;
    end
  end

  assign p_mem_data_out   = valid_q ? rho_mem[last_addr_q] : '0;
  assign ux_mem_data_out  = valid_q ? ux_mem[last_addr_q]  : '0;
  assign uy_mem_data_out  = valid_q ? uy_mem[last_addr_q]  : '0;
  assign fin_mem_data_out = fin_q;

endmodule
`default_nettype wire

// File: tb/tb_lbm_de_2.sv
`default_nettype none
// tb_lbm_de_2 : self-checking bench for lbm_de_2 against a lattice-level
//               D2Q9 reference model evaluated one whole iteration at a time.
module tb_lbm_de_2;

  localparam int DW = 32;
  localparam int NF = 9 * DW;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  logic signed [DW-1:0] p, ux, uy, p2, ux2, uy2;
  logic signed [NF-1:0] fin, fin2;

  always #10 clk = ~clk;

  lbm_de_2 dut (
    .CLOCK_50         (clk),
    .RESET            (rst_n),
    .p_mem_data_out   (p),
    .ux_mem_data_out  (ux),
    .uy_mem_data_out  (uy),
    .fin_mem_data_out (fin)
  );

  // Same engine with the density bump moved to x=15 so it reaches cell 0 across the wrap.
  lbm_de_2 #(.BUMP_ADDR(15)) dut_wrap (
    .CLOCK_50         (clk),
    .RESET            (rst_n),
    .p_mem_data_out   (p2),
    .ux_mem_data_out  (ux2),
    .uy_mem_data_out  (uy2),
    .fin_mem_data_out (fin2)
  );

  int checks = 0;
  int errors = 0;

  int w  [9] = '{32'h0071C71C, 32'h001C71C7, 32'h001C71C7, 32'h001C71C7, 32'h001C71C7,
                 32'h00071C71, 32'h00071C71, 32'h00071C71, 32'h00071C71};
  int cx [9] = '{0, 1, 0, -1, 0, 1, -1, -1, 1};
  int cy [9] = '{0, 0, 1, 0, -1, 1, 1, -1, -1};

  int m_src [256][9];
  int m_dst [256][9];
  int e_rho [256];
  int e_ux  [256];
  int e_uy  [256];
  int e_f   [256][9];

  logic [DW-1:0] prev_p;
  logic [NF-1:0] prev_f;

  function automatic int fmul(input int a, input int b);
    longint prod;
    prod = longint'(a) * longint'(b);
    return int'(prod >>> 24);
  endfunction

  function automatic int times_half(input int q, input int k);
    return int'((longint'(q) * longint'(k)) >>> 1);
  endfunction

  function automatic void model_init(input int bump);
    for (int c = 0; c < 256; c++) begin
      int rho;
      rho = (c == bump) ? 32'h01800000 : 32'h01000000;
      for (int i = 0; i < 9; i++) m_src[c][i] = fmul(w[i], rho);
    end
  endfunction

  function automatic void model_iter();
    for (int c = 0; c < 256; c++) begin
      int x, y, rho, vx, vy, usq, cu, t;
      int f [9];
      x = c % 16;
      y = c / 16;
      rho = 0;
      for (int i = 0; i < 9; i++) begin
        f[i] = m_src[((y - cy[i] + 16) % 16) * 16 + ((x - cx[i] + 16) % 16)][i];
        rho += f[i];
      end
      vx = 0;
      vy = 0;
      for (int i = 0; i < 9; i++) begin
        vx += cx[i] * f[i];
        vy += cy[i] * f[i];
      end
      usq = fmul(vx, vx) + fmul(vy, vy);
      e_rho[c] = rho;
      e_ux[c]  = vx;
      e_uy[c]  = vy;
      for (int i = 0; i < 9; i++) begin
        cu = cx[i] * vx + cy[i] * vy;
        t  = rho + 3 * cu + times_half(fmul(cu, cu), 9) - times_half(usq, 3);
        e_f[c][i]   = fmul(w[i], t);
        m_dst[c][i] = e_f[c][i];
      end
    end
    m_src = m_dst;
  endfunction

  function automatic logic [NF-1:0] pack_f(input int c);
    logic [NF-1:0] v;
    v = '0;
    for (int i = 0; i < 9; i++) v[i*DW +: DW] = e_f[c][i];
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check32(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h, required %h", tag, obs, exp);
    end
  endtask

  task automatic check_f(input string tag, input logic [NF-1:0] obs, input logic [NF-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h, required %h", tag, obs, exp);
    end
  endtask

  task automatic check_near(input string tag, input logic signed [DW-1:0] obs,
                            input logic signed [DW-1:0] target, input int tol);
    int d;
    checks++;
    d = int'(obs) - int'(target);
    assert (d <= tol && d >= -tol)
    else begin
      errors++;
      $error("FAIL %s: observed %h, required %h +/- %0d", tag, obs, target, tol);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check32({tag, "_p"},  p,  '0);
    check32({tag, "_ux"}, ux, '0);
    check32({tag, "_uy"}, uy, '0);
    check_f({tag, "_f"},  fin, '0);
  endtask

  // Release reset and confirm nothing moves during INIT.
  task automatic start_run();
    int nz;
    rst_n = 1'b1;
    model_init(136);
    nz = 0;
    repeat (256) begin
      tick();
      if (p !== '0 || ux !== '0 || uy !== '0 || fin !== '0 || p2 !== '0) nz++;
    end
    check32("init_quiet_cycles", nz, 0);
    prev_p = '0;
    prev_f = '0;
  endtask

  task automatic do_iteration(input int it, input int last_cell);
    model_iter();
    for (int c = 0; c <= last_cell; c++) begin
      int hold;
      hold = (c == 0 && it > 0) ? 11 : 10;
      repeat (hold) tick();
      check32($sformatf("hold_p it%0d c%0d", it, c), p, prev_p);
      check_f($sformatf("hold_f it%0d c%0d", it, c), fin, prev_f);
      tick();
      check32($sformatf("rho it%0d c%0d", it, c), p,  e_rho[c]);
      check32($sformatf("ux it%0d c%0d",  it, c), ux, e_ux[c]);
      check32($sformatf("uy it%0d c%0d",  it, c), uy, e_uy[c]);
      check_f($sformatf("feq it%0d c%0d", it, c), fin, pack_f(c));
      if (it == 0 && c == 0) begin
        check_near("cell0_rho", p, 32'h01000000, 16);
        check_near("cell0_f0", fin[31:0],    32'h0071C71C, 16);
        check_near("cell0_f1", fin[63:32],   32'h001C71C7, 16);
        check_near("cell0_f5", fin[191:160], 32'h00071C71, 16);
        check_near("wrap_rho", p2,  32'h010E38E3, 64);
        check_near("wrap_ux",  ux2, 32'h000E38E3, 64);
        check32("wrap_uy", uy2, '0);
        check_f("wrap_feq", fin2, pack_f(137));
      end
      if (it == 0 && c == 137) begin
        check_near("bump_nb_rho", p,  32'h010E38E3, 64);
        check_near("bump_nb_ux",  ux, 32'h000E38E3, 64);
      end
      prev_p = e_rho[c];
      prev_f = pack_f(c);
    end
  endtask

  initial begin
    int stop_cell;
    int pause;
    int hold_rst;

    rst_n = 1'b0;
    repeat (2) tick();
    check_zero_outputs("reset");

    start_run();
    do_iteration(0, 255);
    stop_cell = $urandom_range(240, 10);
    do_iteration(1, stop_cell);

    pause = $urandom_range(9, 0);
    repeat (pause) tick();
    rst_n = 1'b0;
    #1;
    check_zero_outputs("midrun_reset");
    hold_rst = $urandom_range(4, 1);
    repeat (hold_rst) tick();
    check_zero_outputs("midrun_hold");

    start_run();
    do_iteration(0, 255);
    do_iteration(1, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lbm_de_2.md
LBM_DE_2 -- requirements
Module: lbm_de_2

Interface
REQ-001 The module SHALL have one clock and one reset, with asynchronous active-low reset.
REQ-002 Parameter GRID_DIM, default 256, SHALL be the cell count of a 16x16 lattice.
REQ-003 Parameter DATA_WIDTH, default 32, SHALL be the width of one fixed-point scalar.
REQ-004 Parameter ADDRESS_WIDTH, default $clog2(GRID_DIM)=8, SHALL be the cell address width.
REQ-005 Parameter DATA_WIDTH_F, default 9*DATA_WIDTH=288, SHALL be the packed width of the nine populations.
REQ-006 Parameter FRACTIONAL_BITS, default 24, SHALL be the fraction bits, so the format is Q8.24 and 1.0 = 0x01000000.
REQ-007 Parameter INTEGER_BITS, default DATA_WIDTH-FRACTIONAL_BITS, SHALL be the integer bits including sign.
REQ-008 Port CLOCK_50 SHALL be a 1-bit input clock (50 MHz).
REQ-009 Port RESET SHALL be a 1-bit input: asynchronous, active-low reset.
REQ-010 Port p_mem_data_out SHALL be a signed DATA_WIDTH output carrying the density of the last written cell.
REQ-011 Ports ux_mem_data_out and uy_mem_data_out SHALL be signed DATA_WIDTH outputs carrying the velocity components of the last written cell.
REQ-012 Port fin_mem_data_out SHALL be a signed DATA_WIDTH_F output; f_i occupies bits [32i+31:32i].

Function
REQ-013 The block SHALL be a free-running D2Q9 incompressible BGK lattice-Boltzmann engine with tau=1 (f_out = f_eq), periodic boundaries and cell address = y*16+x.
REQ-014 Directions SHALL be: 0 rest, 1 (+1,0), 2 (0,+1), 3 (-1,0), 4 (0,-1), 5 (+1,+1), 6 (-1,+1), 7 (-1,-1), 8 (+1,-1).
REQ-015 Weights SHALL be: w0=0x0071C71C, w1..4=0x001C71C7, w5..8=0x00071C71.
REQ-016 Storage SHALL consist of two population banks (ping-pong, GRID_DIM x 288 bits) plus rho, ux and uy arrays (GRID_DIM x 32 bits each).
REQ-017 FSM states SHALL be INIT, STREAM, COLLIDE, WRITE and SWAP.
REQ-018 INIT: one cell per cycle over 256 cycles, addresses 0..255; bank0 = w_i*rho, ux=uy=0, rho=1.0 except cell 136 (x=8,y=8), where rho=1.5 (0x01800000); then go to STREAM at address 0.
REQ-019 STREAM: 9 cycles per cell; cycle i pulls f_i from the source bank at neighbour ((x-cx_i) mod 16, (y-cy_i) mod 16).
REQ-020 COLLIDE (1 cycle): rho = sum of f_i; ux = f1-f3+f5-f6-f7+f8; uy = f2-f4+f5+f6-f7-f8 (no division by rho).
REQ-021 COLLIDE also computes cu_i = cx*ux+cy*uy, usq = ux^2+uy^2, and f_eq_i = w_i*(rho + 3cu_i + 4.5cu_i^2 - 1.5usq).
REQ-022 Every product SHALL be a full 64-bit signed product, arithmetically shifted right by FRACTIONAL_BITS and truncated to 32 bits; there is no saturation and no rounding.
REQ-023 WRITE (1 cycle): f_eq goes to the destination bank and rho/ux/uy to their arrays; all four outputs update on the same edge; the address then increments.
REQ-024 After WRITE of address 255 the FSM SHALL enter SWAP (1 cycle), exchange source and destination banks, return to address 0 and continue indefinitely.
REQ-025 Timing SHALL be 11 cycles per cell, 2817 cycles per full iteration (256*11+1) and 256 cycles for INIT.
REQ-026 Outputs SHALL change only in WRITE and hold their value at all other times, including during INIT.

Reset
REQ-027 While RESET=0, all outputs SHALL be 0, the FSM SHALL be in INIT at address 0 and the source bank SHALL be bank0.
REQ-028 Deassertion of RESET SHALL start INIT on the next clock edge.
REQ-029 Assertion of RESET mid-iteration SHALL abort immediately; the next run restarts with a full INIT, and no stale memory content affects results.

Verification
REQ-030 Reset: hold RESET=0 for 2 cycles -> all outputs 0; RESET high -> outputs stay 0 for the 256 INIT cycles plus 10 cycles.
REQ-031 First cell write (cell 0, uniform region) -> p=0x01000000 (within 16 LSB), ux=uy=0, f0 approx 0x0071C71C, f1..4 approx 0x001C71C7, f5..8 approx 0x00071C71.
REQ-032 Neighbour of the bump: cell 137 (9,8), first iteration -> rho = 1 + 0.5/9 approx 0x010E38E3 and ux approx +0x000E38E3 (each within 64 LSB).
REQ-033 Wrap-around: with the bump relocated to cell 15 (x=15) in a test build, cell 0 on iteration 1 -> rho approx 0x010E38E3 via f1.
REQ-034 Cadence: successive output updates SHALL be 11 cycles apart, with a 12-cycle gap across the 255->0 boundary.
REQ-035 Mid-run reset: pulse RESET low in iteration 2 -> outputs 0 immediately, and the sequence after release is identical to the first run.
